// File: rtl/pmux_pipe_if.sv
// pmux_pipe_if: valid/ready stream bundle carrying selects, data words and the resolved result
interface pmux_pipe_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 3,
   parameter int LEVELS = 2
);
   localparam int LVL_W = $clog2(LEVELS + 1);
   logic                           valid_i;
   logic                           ready_o;
   logic [LEVELS*SEL_W-1:0]        sel_i;
   logic [(2**SEL_W)*DATA_W-1:0]   data_i;
   logic                           valid_o;
   logic                           ready_i;
   logic [DATA_W-1:0]              q_o;
   logic [LVL_W-1:0]               level_o;
   modport master (
      output valid_i, sel_i, data_i, ready_i,
      input  ready_o, valid_o, q_o, level_o
   );
   modport slave (
      input  valid_i, sel_i, data_i, ready_i,
      output ready_o, valid_o, q_o, level_o
   );
endinterface

// File: rtl/pmux_pipe.sv
// pmux_pipe: priority-select mux plus per-level offset through a 2-stage valid/ready pipeline; PMUX_PIPE_SAT_EN saturates the adder
module pmux_pipe #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 3,
   parameter int LEVELS = 2
) (
   input logic       clk_i,
   input logic       rst_i,
   pmux_pipe_if.slave bus
);
   localparam int CHANNELS = 2**SEL_W;
   localparam int LVL_W    = $clog2(LEVELS + 1);
   logic [DATA_W-1:0] w_words [CHANNELS];
   logic [SEL_W-1:0]  w_sels  [LEVELS];
   logic [DATA_W-1:0] w_data, w_off, w_sum;
   logic [LVL_W-1:0]  w_lvl;
   logic              w_s1_load, w_s2_load;
   logic              r_s1_valid, r_s2_valid;
   logic [DATA_W-1:0] r_s1_data, r_s1_off, r_q;
   logic [LVL_W-1:0]  r_s1_lvl, r_s2_lvl;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_words
      assign w_words[c] = bus.data_i[c*DATA_W +: DATA_W];
   end
   for (genvar l = 0; l < LEVELS; l++) begin : g_sels
      assign w_sels[l] = bus.sel_i[l*SEL_W +: SEL_W];
   end

   // lowest level not selecting the last channel wins; scanning downward lets it overwrite higher levels
   always_comb begin
      w_data = w_words[CHANNELS-1];
      w_off  = '0;
      w_lvl  = LVL_W'(LEVELS);
      for (int l = LEVELS - 1; l >= 0; l--) begin
         if (w_sels[l] != SEL_W'(CHANNELS - 1)) begin
            w_data = w_words[w_sels[l]];
            w_off  = DATA_W'(l * (CHANNELS - 1) + int'(w_sels[l]) + 1);
            w_lvl  = LVL_W'(l);
         end
      end
   end

`ifdef PMUX_PIPE_SAT_EN
   logic [DATA_W:0] w_full;
   assign w_full = {1'b0, r_s1_data} + {1'b0, r_s1_off};
   assign w_sum  = w_full[DATA_W] ? '1 : w_full[DATA_W-1:0];
`else
   assign w_sum  = r_s1_data + r_s1_off;
`endif

   assign w_s2_load   = ~r_s2_valid | bus.ready_i;
   assign w_s1_load   = ~r_s1_valid | w_s2_load;
   assign bus.ready_o = w_s1_load;
   assign bus.valid_o = r_s2_valid;
   assign bus.q_o     = r_q;
   assign bus.level_o = r_s2_lvl;

   // stage 1 captures the resolved word, offset and level
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_off   <= '0;
         r_s1_lvl   <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= bus.valid_i;
         r_s1_data  <= w_data;
         r_s1_off   <= w_off;
         r_s1_lvl   <= w_lvl;
      end
   end

   // stage 2 captures the sum and forwards the level
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s2_valid <= 1'b0;
         r_q        <= '0;
         r_s2_lvl   <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         r_q        <= w_sum;
         r_s2_lvl   <= r_s1_lvl;
      end
   end
endmodule

// File: tb/tb_pmux_pipe.sv
// tb_pmux_pipe: table vectors, hand sequences and a randomized scoreboard run for pmux_pipe
module tb_pmux_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pmux_pipe_if #(.DATA_W(16), .SEL_W(3), .LEVELS(2)) bus ();
   pmux_pipe #(.DATA_W(16), .SEL_W(3), .LEVELS(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   typedef struct {
      logic [5:0]   sel;
      logic [127:0] data;
      logic [15:0]  q;
      logic [1:0]   lvl;
   } vec_t;
   typedef struct {
      logic [15:0] q;
      logic [1:0]  lvl;
   } exp_t;

   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   logic prev_stall = 1'b0;
   logic [15:0] prev_q = '0;
   vec_t tv[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] mk(input int ch, input logic [15:0] v);
      logic [127:0] d = {8{16'hA5A5}};
      d[ch*16 +: 16] = v;
      return d;
   endfunction

   // model: first level whose select is not 7 picks channel s with offset l*7+s+1
   function automatic exp_t ref_beat(input logic [5:0] sel, input logic [127:0] data);
      exp_t e;
      int ch = 7;
      int off = 0;
      int sum;
      logic [127:0] t;
      e.lvl = 2'd2;
      for (int l = 1; l >= 0; l--) begin
         int s = int'((sel >> (3 * l)) & 6'd7);
         if (s != 7) begin
            ch = s;
            off = l * 7 + s + 1;
            e.lvl = 2'(l);
         end
      end
      t = data >> (16 * ch);
      sum = int'(t[15:0]) + off;
`ifdef PMUX_PIPE_SAT_EN
      e.q = (sum > 65535) ? 16'hFFFF : 16'(sum);
`else
      e.q = 16'(sum % 65536);
`endif
      return e;
   endfunction

   task automatic do_reset();
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      bus.sel_i   = '0;
      bus.data_i  = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      prev_stall = 1'b0;
      @(negedge clk);
   endtask

   task automatic step(output logic acc, output logic emi, output logic rdy, output logic [15:0] q);
      exp_t e;
      #1;
      rdy = bus.ready_o;
      q   = bus.q_o;
      acc = bus.valid_i && bus.ready_o;
      emi = bus.valid_o && bus.ready_i;
      if (prev_stall) begin
         check("stall_valid", 32'(bus.valid_o), 32'd1);
         check("stall_q", 32'(bus.q_o), 32'(prev_q));
      end
      if (emi) begin
         if (sb.size() == 0) begin
            check("spurious_beat", 32'(bus.q_o), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("sb_q", 32'(bus.q_o), 32'(e.q));
            check("sb_level", 32'(bus.level_o), 32'(e.lvl));
         end
      end
      if (acc) sb.push_back(ref_beat(bus.sel_i, bus.data_i));
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_q = bus.q_o;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic acc, emi, rdy, saw_low;
      logic [15:0] q;
      int k, got;
      tv[0] = '{6'({3'd0, 3'd2}), mk(2, 16'd100), 16'd103, 2'd0};
      tv[1] = '{6'({3'd4, 3'd7}), mk(4, 16'd50), 16'd62, 2'd1};
      tv[2] = '{6'({3'd0, 3'd7}), mk(0, 16'd1000), 16'd1008, 2'd1};
      tv[3] = '{6'({3'd7, 3'd7}), mk(7, 16'h1234), 16'h1234, 2'd2};
`ifdef PMUX_PIPE_SAT_EN
      tv[4] = '{6'({3'd0, 3'd6}), mk(6, 16'hFFFC), 16'hFFFF, 2'd0};
`else
      tv[4] = '{6'({3'd0, 3'd6}), mk(6, 16'hFFFC), 16'h0003, 2'd0};
`endif
      tv[5] = '{6'({3'd6, 3'd7}), mk(6, 16'hFFF0), 16'hFFFE, 2'd1};
      tv[6] = '{6'({3'd3, 3'd0}), mk(0, 16'd5), 16'd6, 2'd0};

      do_reset();
      check("rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("rst_q_o", 32'(bus.q_o), 32'd0);
      check("rst_level_o", 32'(bus.level_o), 32'd0);
      check("rst_ready_o", 32'(bus.ready_o), 32'd1);

      for (int i = 0; i < 7; i++) begin
         bus.valid_i = 1'b1;
         bus.ready_i = 1'b1;
         bus.sel_i   = tv[i].sel;
         bus.data_i  = tv[i].data;
         @(posedge clk);
         #1 bus.valid_i = 1'b0;
         check("vec_early_valid", 32'(bus.valid_o), 32'd0);
         @(posedge clk);
         #1;
         check("vec_valid", 32'(bus.valid_o), 32'd1);
         check("vec_q", 32'(bus.q_o), 32'(tv[i].q));
         check("vec_level", 32'(bus.level_o), 32'(tv[i].lvl));
         @(posedge clk);
         @(negedge clk);
      end

      do_reset();
      k = 0;
      got = 0;
      saw_low = 1'b0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         bus.valid_i = (k < 4);
         bus.sel_i   = {3'd7, 3'(k)};
         bus.data_i  = mk(k % 8, 16'((k + 1) * 10));
         bus.ready_i = !(cyc >= 2 && cyc <= 5);
         step(acc, emi, rdy, q);
         if (!rdy) saw_low = 1'b1;
         if (cyc >= 2 && cyc <= 5) check("bp_hold_q", 32'(q), 32'd11);
         if (cyc >= 6 && !emi) check("bp_gap", 32'(emi), 32'd1);
         if (acc) k++;
         if (emi) begin
            check("bp_seq", 32'(q), 32'((got + 1) * 11));
            got++;
         end
      end
      bus.valid_i = 1'b0;
      check("bp_count", 32'(got), 32'd4);
      check("bp_ready_low", 32'(saw_low), 32'd1);

      do_reset();
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      bus.sel_i   = {3'd7, 3'd1};
      bus.data_i  = mk(1, 16'd77);
      step(acc, emi, rdy, q);
      check("mr_acc0", 32'(acc), 32'd1);
      bus.data_i  = mk(1, 16'd88);
      step(acc, emi, rdy, q);
      check("mr_acc1", 32'(acc), 32'd1);
      bus.valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      prev_stall = 1'b0;
      check("mr_valid_o", 32'(bus.valid_o), 32'd0);
      check("mr_q_o", 32'(bus.q_o), 32'd0);
      check("mr_level_o", 32'(bus.level_o), 32'd0);
      check("mr_ready_o", 32'(bus.ready_o), 32'd1);
      @(negedge clk);
      bus.ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(acc, emi, rdy, q);
         if (emi) check("mr_ghost_beat", 32'(emi), 32'd0);
      end

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bus.valid_i = ($urandom_range(0, 3) != 0);
         bus.ready_i = ($urandom_range(0, 3) != 0);
         bus.sel_i   = {($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7))};
         bus.data_i  = {$urandom, $urandom, $urandom, $urandom};
         step(acc, emi, rdy, q);
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 10 && sb.size() > 0; i++) step(acc, emi, rdy, q);
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
